// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers for the MIPS execute stage.
// Multi-cycle mult/multu/div/divu with Busy/Cancel handshake; single-edge mthi/mtlo.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [2:0]       MDOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cancel,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] C_MULT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] C_DIV  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_hi, r_lo;
  logic [2:0]       r_op;
  logic             r_busy;

  logic               w_signed, w_neg_a, w_neg_b, w_div_zero;
  logic [2*WIDTH-1:0] w_ext_a, w_ext_b, w_prod;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_quo, w_rem, w_res_hi, w_res_lo;

  // Result from latched operands; signed divide works on magnitudes, then restores signs.
  always_comb begin
    w_signed   = (r_op == OP_MULT) || (r_op == OP_DIV);
    w_neg_a    = w_signed & r_a[WIDTH-1];
    w_neg_b    = w_signed & r_b[WIDTH-1];
    w_div_zero = ((r_op == OP_DIV) || (r_op == OP_DIVU)) && (r_b == '0);
    w_ext_a    = {{WIDTH{w_neg_a}}, r_a};
    w_ext_b    = {{WIDTH{w_neg_b}}, r_b};
    w_prod     = w_ext_a * w_ext_b;
    w_mag_a    = w_neg_a ? (-r_a) : r_a;
    w_mag_b    = w_neg_b ? (-r_b) : r_b;
    if (w_mag_b != '0) begin
      w_quo = w_mag_a / w_mag_b;
      w_rem = w_mag_a % w_mag_b;
    end else begin
      w_quo = '0;
      w_rem = '0;
    end
    case (r_op)
      OP_MULT, OP_MULTU: begin
        w_res_hi = w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod[WIDTH-1:0];
      end
      OP_DIV, OP_DIVU: begin
        w_res_hi = w_neg_a ? (-w_rem) : w_rem;
        w_res_lo = (w_neg_a ^ w_neg_b) ? (-w_quo) : w_quo;
      end
      default: begin
        w_res_hi = r_hi;
        w_res_lo = r_lo;
      end
    endcase
  end

  // Control FSM with registered HI/LO/Busy; Cancel takes priority over Start and completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start && !Cancel) begin
            case (MDOp)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                r_a     <= A;
                r_b     <= B;
                r_op    <= MDOp;
                r_cnt   <= (MDOp == OP_MULT || MDOp == OP_MULTU) ? C_MULT : C_DIV;
                r_state <= S_RUN;
                r_busy  <= 1'b1;
              end
              OP_MTHI: r_hi <= A;
              OP_MTLO: r_lo <= A;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (Cancel) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == C_ONE) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            if (!w_div_zero) begin
              r_hi <= w_res_hi;
              r_lo <= w_res_lo;
            end
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy = r_busy;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: a 32-bit and a 16-bit instance against a behavioural model.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset, start, cancel;
  logic [2:0]  mdop;
  logic [31:0] a, b;
  logic        busy0, busy1;
  logic [31:0] hi0, lo0;
  logic [15:0] hi1, lo1;

  int n_vec = 0;
  int n_mis = 0;
  int sel = 0;
  int wd = 32;
  int nm = 5;
  int nd = 10;
  logic [63:0] sb_q[$];
  logic [31:0] m_hi, m_lo;
  logic        o_busy;
  logic [31:0] o_hi, o_lo;

  always #5 clk = ~clk;

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut32 (
    .clk(clk), .reset(reset), .Start(start), .MDOp(mdop), .A(a), .B(b),
    .Cancel(cancel), .Busy(busy0), .HI(hi0), .LO(lo0));

  md_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) u_dut16 (
    .clk(clk), .reset(reset), .Start(start), .MDOp(mdop), .A(a[15:0]), .B(b[15:0]),
    .Cancel(cancel), .Busy(busy1), .HI(hi1), .LO(lo1));

  assign o_busy = (sel != 0) ? busy1 : busy0;
  assign o_hi   = (sel != 0) ? {16'h0000, hi1} : hi0;
  assign o_lo   = (sel != 0) ? {16'h0000, lo1} : lo0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input int w, input logic [2:0] op, input logic [31:0] av,
                                        input logic [31:0] bv, input logic [31:0] hv, input logic [31:0] lv);
    logic [63:0] mask, ua, ub, p;
    logic signed [63:0] sa, sb, q, r;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, av} & mask;
    ub = {32'd0, bv} & mask;
    sa = $signed(ua << (64 - w)) >>> (64 - w);
    sb = $signed(ub << (64 - w)) >>> (64 - w);
    case (op)
      3'd1: begin p = sa * sb; return {32'((p >> w) & mask), 32'(p & mask)}; end
      3'd2: begin p = ua * ub; return {32'((p >> w) & mask), 32'(p & mask)}; end
      3'd3: begin
        if (ub == 64'd0) return {hv, lv};
        q = sa / sb;
        r = sa % sb;
        return {32'(r & mask), 32'(q & mask)};
      end
      3'd4: begin
        if (ub == 64'd0) return {hv, lv};
        return {32'((ua % ub) & mask), 32'((ua / ub) & mask)};
      end
      3'd5: return {32'(ua), lv};
      3'd6: return {hv, 32'(ua)};
      default: return {hv, lv};
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1; start = 1'b0; cancel = 1'b0; mdop = 3'd0;
    step();
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    check({tag, "_busy"}, 64'(o_busy), 64'd0);
    check({tag, "_hi"}, 64'(o_hi), 64'd0);
    check({tag, "_lo"}, 64'(o_lo), 64'd0);
  endtask

  // Launch a multi-cycle op, optionally injecting ignored Starts or a Cancel while it runs.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input int cancel_at, input bit inject);
    int n, cnt;
    logic [63:0] e;
    n = (op <= 3'd2) ? nm : nd;
    start = 1'b1; mdop = op; a = av; b = bv;
    sb_q.push_back((cancel_at == 0) ? model(wd, op, av, bv, m_hi, m_lo) : {m_hi, m_lo});
    step();
    start = 1'b0; mdop = 3'd0; a = $urandom; b = $urandom;
    cnt = 0;
    while (o_busy === 1'b1 && cnt < 200) begin
      cnt++;
      if (inject && cnt == 2) begin start = 1'b1; mdop = 3'd6; a = 32'h5A5A; end
      if (inject && cnt == 3) begin start = 1'b1; mdop = 3'd1; a = 32'd9; b = 32'd9; end
      if (cnt == cancel_at) cancel = 1'b1;
      step();
      start = 1'b0; mdop = 3'd0; cancel = 1'b0;
    end
    check({tag, "_busy_cycles"}, 64'(cnt), 64'((cancel_at != 0) ? cancel_at : n));
    e = sb_q.pop_front();
    m_hi = e[63:32]; m_lo = e[31:0];
    check({tag, "_hi"}, 64'(o_hi), 64'(e[63:32]));
    check({tag, "_lo"}, 64'(o_lo), 64'(e[31:0]));
  endtask

  task automatic move_to(input string tag, input logic [2:0] op, input logic [31:0] av);
    logic [63:0] e;
    start = 1'b1; mdop = op; a = av;
    sb_q.push_back(model(wd, op, av, 32'd0, m_hi, m_lo));
    step();
    start = 1'b0; mdop = 3'd0;
    e = sb_q.pop_front();
    m_hi = e[63:32]; m_lo = e[31:0];
    check({tag, "_busy"}, 64'(o_busy), 64'd0);
    check({tag, "_hi"}, 64'(o_hi), 64'(e[63:32]));
    check({tag, "_lo"}, 64'(o_lo), 64'(e[31:0]));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; cancel = 1'b0; mdop = 3'd0; a = 32'd0; b = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    step();
    do_reset("reset");

    run_op("mult_neg", 3'd1, 32'hFFFFFFFD, 32'd5, 0, 1'b0);
    check("mult_neg_const_hi", 64'(o_hi), 64'hFFFFFFFF);
    check("mult_neg_const_lo", 64'(o_lo), 64'hFFFFFFF1);
    run_op("multu", 3'd2, 32'hFFFFFFFF, 32'd2, 0, 1'b0);
    run_op("divu", 3'd4, 32'd100, 32'd7, 0, 1'b0);
    check("divu_const_lo", 64'(o_lo), 64'd14);
    run_op("div_neg", 3'd3, 32'hFFFFFFF9, 32'd2, 0, 1'b0);
    run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0);
    move_to("mthi11", 3'd5, 32'h11);
    move_to("mtlo22", 3'd6, 32'h22);
    run_op("div_zero", 3'd3, 32'd5, 32'd0, 0, 1'b0);
    check("div_zero_const_hi", 64'(o_hi), 64'h11);
    move_to("mthi_dead", 3'd5, 32'hDEAD);
    run_op("mult_inject", 3'd1, 32'd3, 32'd4, 0, 1'b1);
    move_to("mtlo_cl", 3'd6, 32'h77);
    run_op("cancel_c2", 3'd1, 32'd3, 32'd4, 2, 1'b0);
    run_op("cancel_last", 3'd1, 32'd7, 32'd8, 5, 1'b0);

    start = 1'b1; mdop = 3'd1; a = 32'd6; b = 32'd6; cancel = 1'b1;
    step();
    start = 1'b0; mdop = 3'd0; cancel = 1'b0;
    check("idle_cancel_busy", 64'(o_busy), 64'd0);
    step();
    check("idle_cancel_busy2", 64'(o_busy), 64'd0);
    check("idle_cancel_hi", 64'(o_hi), 64'(m_hi));
    check("idle_cancel_lo", 64'(o_lo), 64'(m_lo));

    for (int i = 0; i < 8; i++) begin
      run_op("rand32", 3'(1 + (i % 4)), $urandom, ((i % 5) == 4) ? 32'd0 : $urandom, 0, 1'b0);
    end

    start = 1'b1; mdop = 3'd4; a = 32'd1000; b = 32'd3;
    step();
    start = 1'b0; mdop = 3'd0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_busy", 64'(o_busy), 64'd0);
    check("rst_mid_hi", 64'(o_hi), 64'd0);
    check("rst_mid_lo", 64'(o_lo), 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;

    sel = 1; wd = 16; nm = 1; nd = 3;
    do_reset("reset16");
    run_op("mult16_min", 3'd1, 32'h8000, 32'h8000, 0, 1'b0);
    check("mult16_const_hi", 64'(o_hi), 64'h4000);
    run_op("div16_ovf", 3'd3, 32'h8000, 32'hFFFF, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      run_op("rand16", 3'(1 + (i % 4)), $urandom, $urandom, 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multiply/divide unit with HI/LO registers for the next-generation MIPS core. It executes mult, multu, div, divu, mthi and mtlo with configurable operand width and per-class latency. While an operation is in flight it raises a busy flag so the core can stall, and it accepts a cancel so the core can squash an in-flight operation. It sits beside the ALU in the execute stage, and the controller drives its MDOp field.

## Interface
- WIDTH, 32, operand and HI/LO width in bits (>= 2)
- MULT_CYCLES, 5, cycles from accepted mult/multu to result (>= 1)
- DIV_CYCLES, 10, cycles from accepted div/divu to result (>= 1)

- clk  in  1  clock; single clock domain, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- Start  in  1  launch request, qualified by MDOp
- MDOp  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (no-op)
- A  in  WIDTH  rs operand (dividend / multiplicand / mthi-mtlo source)
- B  in  WIDTH  rt operand (divisor / multiplier)
- Cancel  in  1  abort in-flight operation
- Busy  out  1  operation in flight
- HI  out  WIDTH  HI register (product high half / remainder)
- LO  out  WIDTH  LO register (product low half / quotient)

## Operation
- Reset: HI=0, LO=0, Busy=0, internal counter 0. These values apply at the first edge with reset=1, regardless of other inputs. Reset mid-operation discards the operation.
- States: IDLE (Busy=0) and RUN (Busy=1, counter 1..N).
- IDLE, Start=1, MDOp in 1..4, Cancel=0:
  - Latch A, B and MDOp, load counter with N, go to RUN.
  - N=MULT_CYCLES for MDOp 1..2; N=DIV_CYCLES for MDOp 3..4.
- IDLE, Start=1, MDOp=5: HI<=A next edge. MDOp=6: LO<=A next edge. Busy stays 0.
- IDLE, Start=1, MDOp 0 or 7: no effect.
- RUN: counter decrements each edge. On the edge where it reaches 0, HI/LO are written, Busy=0, and state returns to IDLE.
- RUN, Start=1 with any MDOp, including mthi/mtlo: ignored, not queued. The core is required to stall.
- Cancel=1: in RUN, go to IDLE on next edge with HI/LO unchanged. In IDLE, it has no effect.
- Cancel together with Start in IDLE: Cancel wins and Start is ignored.
- Cancel on the final RUN edge: Cancel wins and HI/LO are unchanged.
- Arithmetic (2*WIDTH product, truncated division):
  - mult: signed A*B; HI=upper WIDTH bits, LO=lower WIDTH bits.
  - multu: same, with unsigned operands.
  - div: signed; LO=quotient truncated toward zero; HI=remainder, taking the sign of the dividend.
  - div with most-negative / -1: LO=most-negative, HI=0 (two's-complement wrap, no trap).
  - divu: unsigned quotient and remainder.
  - Divide by zero (B=0): operation still runs DIV_CYCLES with Busy behaving normally; HI/LO are left unchanged.
- The result is computed from latched operands. A/B changes during RUN have no effect.
- Internal computation style (iterative or precomputed and delayed) is an implementation choice. Only the cycle-level behaviour below is normative.

## Timing
- Start accepted at edge E0: Busy=1 from after E0 through edge E0+N-1. At edge E0+N, HI/LO take the result and Busy falls.
- Busy is therefore high for exactly N cycles.
- HI/LO hold their previous values through the whole RUN state. No partial results are visible.
- A new Start may be accepted at edge E0+N+1 at the earliest, i.e. in the first cycle Busy reads 0. Back-to-back operations have no bubble beyond that cycle.
- mthi/mtlo: single edge, zero busy cycles. HI/LO are visible the cycle after the edge.
- HI, LO and Busy are registered outputs with no combinational path from inputs.

## Test plan
- Reset, then mult A=0xFFFFFFFD (-3), B=5 (WIDTH=32, MULT_CYCLES=5) -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- multu A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE. divu A=100, B=7 -> after 10 Busy cycles, LO=14, HI=2.
- div A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0. div A=5, B=0 with prior HI=0x11, LO=0x22 -> 10 Busy cycles, HI/LO still 0x11/0x22.
- mthi A=0xDEAD issued in IDLE -> HI=0xDEAD next cycle, Busy never rises. mtlo and a second mult issued during RUN -> both ignored; the first result is unaffected.
- mult 3*4 started, Cancel on cycle 2 of RUN -> Busy=0 next cycle, HI/LO unchanged. Cancel on the final RUN cycle -> also unchanged. Start+Cancel in IDLE -> no operation.
- reset asserted mid-div -> next cycle HI=LO=0, Busy=0. Repeat with WIDTH=16, MULT_CYCLES=1: mult 0x8000*0x8000 (signed) -> 1 Busy cycle; HI=0x4000, LO=0x0000.
